// File: rtl/regfile_dump.sv
// regfile_dump: reads lenght registers and streams each word MSB-first as bytes.
// Define REGFILE_DUMP_CHECKSUM_EN to append an XOR checksum byte to every dump.
module regfile_dump #(
   parameter int width  = 32,
   parameter int lenght = 32,
   parameter int NB     = $clog2(lenght)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic [NB-1:0]    reg_addr,
   input  logic [width-1:0] reg_data,
   output logic [7:0]       tx_data,
   output logic             tx_start,
   input  logic             tx_done,
   output logic             busy,
   output logic             done
);
   localparam int NBYTES = width / 8;
   localparam int IW = NBYTES > 1 ? $clog2(NBYTES) : 1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
   typedef enum logic [3:0] {IDLE, ADDR, LOAD, SEND, WAIT, NEXT, CHK_SEND, CHK_WAIT, FINISH} state_t;
   localparam state_t AFTER_LAST = CHK_SEND;
`else
   typedef enum logic [2:0] {IDLE, ADDR, LOAD, SEND, WAIT, NEXT, FINISH} state_t;
   localparam state_t AFTER_LAST = FINISH;
`endif
   state_t state, state_nxt;
   logic [width-1:0] word;
   logic [width-1:0] word_sh;
   logic [IW-1:0] idx;
   logic [7:0] cur_byte;
   logic last_byte, last_reg, accept;
   // Byte idx counts from the MSB end, so shifting left brings it to the top.
   assign word_sh   = word << {idx, 3'b000};
   assign cur_byte  = word_sh[width-1 -: 8];
   assign last_byte = idx == IW'(NBYTES - 1);
   assign last_reg  = reg_addr == NB'(lenght - 1);
   assign accept    = state == IDLE && start;
   assign busy      = state != IDLE && state != FINISH;
   assign done      = state == FINISH;
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     state_nxt = start ? ADDR : IDLE;
         ADDR:     state_nxt = LOAD;
         LOAD:     state_nxt = SEND;
         SEND:     state_nxt = WAIT;
         WAIT:     state_nxt = tx_done ? (last_byte ? NEXT : SEND) : WAIT;
         NEXT:     state_nxt = last_reg ? AFTER_LAST : ADDR;
`ifdef REGFILE_DUMP_CHECKSUM_EN
         CHK_SEND: state_nxt = CHK_WAIT;
         CHK_WAIT: state_nxt = tx_done ? FINISH : CHK_WAIT;
`endif
         FINISH:   state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         reg_addr <= '0;
         idx      <= '0;
         word     <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            reg_addr <= '0;
            idx      <= '0;
         end
         if (state == LOAD) word <= reg_data;
         if (state == WAIT && tx_done) idx <= last_byte ? '0 : idx + 1'b1;
         if (state == NEXT && !last_reg) reg_addr <= reg_addr + 1'b1;
      end
   end
`ifdef REGFILE_DUMP_CHECKSUM_EN
   logic [7:0] chk;
   always_ff @(posedge clk) begin
      if (reset || accept) chk <= '0;
      else if (state == SEND) chk <= chk ^ cur_byte;
   end
   assign tx_start = state == SEND || state == CHK_SEND;
   assign tx_data  = (state == CHK_SEND || state == CHK_WAIT) ? chk : cur_byte;
`else
   assign tx_start = state == SEND;
   assign tx_data  = cur_byte;
`endif
endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: randomized dumps against a queue-based byte-stream model of the register file.
module tb_regfile_dump;
   localparam int W = 32, L = 32, NB = 5, NBY = W / 8;
   logic clk = 0, reset = 1;
   logic start_main = 0, start_noise = 0, model_done = 0, idle_done = 0;
   logic start, tx_done, tx_start, busy, done;
   logic [NB-1:0] reg_addr;
   logic [W-1:0] reg_data, scramble = '0;
   logic [7:0] tx_data, held;
   logic [W-1:0] regs [L];
   int gap = 3, stable_err = 0, done_cnt = 0, pos = 0;
   int n_checks = 0, n_errors = 0;
   bit mutate = 0, noise_en = 0, waiting = 0;
   logic [7:0] got_q[$];
   int addr_q[$];

   assign start    = start_main | start_noise;
   assign tx_done  = model_done | idle_done;
   assign reg_data = regs[reg_addr] ^ scramble;

   always #5 clk = ~clk;

   regfile_dump #(.width(W), .lenght(L), .NB(NB)) dut (
      .clk(clk), .reset(reset), .start(start), .reg_addr(reg_addr), .reg_data(reg_data),
      .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done), .busy(busy), .done(done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Transmitter: raises tx_done for one cycle, sampled gap cycles after tx_start.
   initial forever begin
      @(posedge clk); #1;
      model_done = 0;
      if (tx_start) begin
         repeat (gap - 1) begin @(posedge clk); #1; end
         model_done = 1;
      end
   end

   always @(negedge clk) start_noise = noise_en && busy && ($urandom_range(0, 3) == 0);

   // Byte collector, stability watcher, and reg_data corrupter while a word is in flight.
   always @(negedge clk) begin
      if (reset) begin
         waiting = 0;
         pos = 0;
         scramble = '0;
      end else begin
         if (tx_start) begin
            if (waiting) stable_err++;
            got_q.push_back(tx_data);
            addr_q.push_back(int'(reg_addr));
            waiting = 1;
            held = tx_data;
            if (mutate && pos == 0) scramble = $urandom;
            pos = (pos + 1) % NBY;
         end else if (waiting && tx_data !== held) stable_err++;
         if (tx_done && waiting) begin
            waiting = 0;
            if (pos == 0) scramble = '0;
         end
         if (done) begin
            done_cnt++;
            pos = 0;
            scramble = '0;
         end
      end
   end

   task automatic run_dump(input string name);
      int base = got_q.size(), base_done = done_cnt, base_err = stable_err, t = 0;
      logic [7:0] exp_q[$];
      logic [7:0] c = '0, by;
      for (int i = 0; i < L; i++)
         for (int b = 0; b < NBY; b++) begin
            by = 8'(regs[i] >> (8 * (NBY - 1 - b)));
            exp_q.push_back(by);
            c ^= by;
         end
`ifdef REGFILE_DUMP_CHECKSUM_EN
      exp_q.push_back(c);
`endif
      @(negedge clk) start_main = 1;
      @(negedge clk) start_main = 0;
      check({name, "_busy_start"}, 32'(busy), 1);
      while (!done && t < 20000) begin @(negedge clk); t++; end
      check({name, "_done_seen"}, 32'(done), 1);
      check({name, "_busy_at_done"}, 32'(busy), 0);
      start_main = 1;
      @(negedge clk) start_main = 0;
      check({name, "_done_width"}, 32'(done), 0);
      repeat (5) @(negedge clk);
      check({name, "_busy_after"}, 32'(busy), 0);
      check({name, "_byte_count"}, got_q.size() - base, exp_q.size());
      for (int j = 0; j < exp_q.size(); j++)
         if (base + j < got_q.size()) begin
            check($sformatf("%s_byte%0d", name, j), 32'(got_q[base + j]), 32'(exp_q[j]));
            if (j < L * NBY) check($sformatf("%s_addr%0d", name, j), addr_q[base + j], j / NBY);
         end
      check({name, "_stable"}, stable_err - base_err, 0);
      check({name, "_done_pulses"}, done_cnt - base_done, 1);
   endtask

   task automatic reset_abort();
      int base = got_q.size(), t = 0;
      gap = 3;
      @(negedge clk) start_main = 1;
      @(negedge clk) start_main = 0;
      while (got_q.size() - base < 41 && t < 20000) begin @(negedge clk); t++; end
      check("abort_reached_byte40", got_q.size() - base, 41);
      @(negedge clk) reset = 1;
      @(negedge clk) reset = 0;
      check("abort_busy", 32'(busy), 0);
      check("abort_addr", 32'(reg_addr), 0);
      check("abort_tx_start", 32'(tx_start), 0);
      check("abort_tx_data", 32'(tx_data), 0);
      repeat (30) @(negedge clk);
      check("abort_no_more_bytes", got_q.size() - base, 41);
      check("abort_idle", 32'(busy), 0);
   endtask

   initial begin
      for (int i = 0; i < L; i++) regs[i] = 32'h01010101 * i;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_tx_start", 32'(tx_start), 0);
      check("rst_addr", 32'(reg_addr), 0);
      check("rst_tx_data", 32'(tx_data), 0);
      reset = 0;
      repeat (3) begin
         @(negedge clk) idle_done = 1;
         @(negedge clk) idle_done = 0;
      end
      repeat (3) @(negedge clk);
      check("idle_txdone_busy", 32'(busy), 0);
      check("idle_txdone_bytes", got_q.size(), 0);
      run_dump("ramp");
      regs[5] = 32'hDEADBEEF;
      run_dump("deadbeef");
      for (int i = 0; i < L; i++) regs[i] = '0;
      regs[1] = 32'h000000A5;
      run_dump("chk_a5");
      noise_en = 1;
      mutate = 1;
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < L; i++) regs[i] = $urandom;
         gap = $urandom_range(2, 6);
         run_dump($sformatf("rand%0d", r));
      end
      noise_en = 0;
      mutate = 0;
      gap = 52;
      run_dump("hold");
      for (int i = 0; i < L; i++) regs[i] = 32'h01010101 * i;
      reset_abort();
      run_dump("restart");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/regfile_dump.md
REGFILE_DUMP -- requirements
Module: regfile_dump

Interface
REQ-001 Parameter width, default 32, bit width of one register word; SHALL be a multiple of 8.
REQ-002 Parameter lenght, default 32, number of registers to read back.
REQ-003 Parameter NB, default $clog2(lenght), register address width.
REQ-004 Port clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port start  input  1  dump request, sampled only in IDLE.
REQ-007 Port reg_addr  output  NB  read address to the register file's combinational read port.
REQ-008 Port reg_data  input  width  combinational read data for reg_addr.
REQ-009 Port tx_data  output  8  byte to the byte transmitter.
REQ-010 Port tx_start  output  1  one-cycle pulse, tx_data valid.
REQ-011 Port tx_done  input  1  transmitter finished the current byte.
REQ-012 Port busy  output  1  high from the cycle after start acceptance until done.
REQ-013 Port done  output  1  one-cycle pulse after the final byte completes.

Function
REQ-014 States SHALL be: IDLE, ADDR, LOAD, SEND, WAIT, NEXT, CHK_SEND, CHK_WAIT, FINISH.
REQ-015 IDLE + start=1 -> ADDR; reg_addr<=0, byte index<=0; busy=1 from the next cycle.
REQ-016 ADDR SHALL hold reg_addr for one cycle; LOAD SHALL capture reg_data into an internal word register.
REQ-017 Bytes SHALL be sent MSB first: bits [width-1:width-8] first, bits [7:0] last, width/8 bytes per word.
REQ-018 SEND SHALL drive tx_data with the current byte and assert tx_start for exactly one cycle, then go to WAIT.
REQ-019 tx_data SHALL remain stable from SEND until tx_done is sampled high in WAIT.
REQ-020 WAIT + tx_done=1 -> SEND for the next byte of the word, or NEXT after the last byte; tx_done in any other state SHALL be ignored.
REQ-021 NEXT: if reg_addr==lenght-1 -> CHK_SEND (macro on) or FINISH (macro off); otherwise reg_addr<=reg_addr+1 -> ADDR.
REQ-022 reg_addr SHALL NOT wrap past lenght-1 and SHALL hold its final value until the next start.
REQ-023 FINISH SHALL assert done for one cycle, clear busy and return to IDLE.
REQ-024 start while busy=1 SHALL be ignored; a start coincident with the done pulse SHALL be ignored.
REQ-025 The word register SHALL be captured only in LOAD, so changes on reg_data during byte transmission SHALL NOT affect the bytes sent.
REQ-026 Total bytes per dump SHALL be lenght*width/8, plus 1 with the macro on.

Reset
REQ-027 reset=1 SHALL force IDLE with reg_addr=0, tx_data=0, tx_start=0, busy=0, done=0, word register=0 and checksum=0.
REQ-028 reset asserted mid-dump SHALL abort the dump; no tx_start SHALL occur in the cycle after reset is sampled.
REQ-029 reset SHALL take priority over start and tx_done in the same cycle.

Configuration
REQ-030 Macro REGFILE_DUMP_CHECKSUM_EN defined: an 8-bit XOR of every data byte sent SHALL be transmitted as one extra byte via CHK_SEND/CHK_WAIT, using the same tx_start/tx_done rules, before FINISH.
REQ-031 Macro undefined: the checksum logic and the CHK states SHALL be absent, and NEXT SHALL go directly to FINISH.
REQ-032 The checksum SHALL clear to 0 on start acceptance.

Verification
REQ-033 Model regs i = 0x01010101*i; pulse start with a tx model returning tx_done 3 cycles after each tx_start -> 128 bytes: 00 00 00 00 01 01 01 01 ... 1F 1F 1F 1F, then done for one cycle; busy low afterwards.
REQ-034 reg 5 = 0xDEADBEEF -> bytes 20..23 SHALL be DE AD BE EF, with reg_addr=5 during capture.
REQ-035 Macro on, all regs 0 except reg 1 = 0x000000A5 -> 129th byte SHALL be A5; macro off -> exactly 128 bytes, no checksum byte.
REQ-036 Assert reset during WAIT of byte 40 -> next cycle busy=0, reg_addr=0, no further tx_start; a new start SHALL restart from reg 0.
REQ-037 start pulsed while busy, and tx_done pulsed in IDLE -> no effect on the byte sequence or state.
REQ-038 Hold tx_done low for 50 cycles in WAIT -> tx_data held stable, a single tx_start only, no progress until tx_done.
